// File: rtl/stack_ctrl_v2_pkg.sv
// Shared types and constants for the stack CPU multicycle controller.
package stack_ctrl_v2_pkg;

    typedef enum logic [4:0] {
        StIdle, StFetch, StDecode,
        StPushRd, StPushWr,
        StPopRd, StPopLd, StPopWr,
        StJmp, StJzTos, StJzEv,
        StBinP1, StBinLa, StBinP2, StBinEx, StBinPu,
        StUnP, StUnLa,
        StFault
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_J    = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_OVF  = 2'b01;
    localparam logic [1:0] FAULT_UNF  = 2'b10;
    localparam logic [1:0] FAULT_TMO  = 2'b11;

    localparam int unsigned ALU_PASS = 0;

    // Moore strobes; ir_write and the FETCH pc_write are qualified by mem_ack in the top.
    typedef struct packed {
        logic pc_src;
        logic pc_write;
        logic pc_write_con;
        logic mem_sel;
        logic mem_read;
        logic mem_write;
        logic stack_sel;
        logic load_a;
        logic a_sel;
        logic b_sel;
        logic push;
        logic pop;
        logic tos;
        logic alu_use_op;
    } strobes_t;

    function automatic strobes_t decode_strobes(state_e s);
        strobes_t st;
        st = '0;
        case (s)
            StFetch:  st.mem_read = 1'b1;
            StPushRd: begin st.mem_read = 1'b1; st.mem_sel = 1'b1; end
            StPushWr: begin st.push = 1'b1; st.stack_sel = 1'b1; end
            StPopRd, StBinP1, StBinP2, StUnP: st.pop = 1'b1;
            StPopLd, StBinLa, StUnLa: st.load_a = 1'b1;
            StPopWr:  begin st.mem_write = 1'b1; st.mem_sel = 1'b1; end
            StJmp:    begin st.pc_write = 1'b1; st.pc_src = 1'b1; end
            StJzTos:  begin st.tos = 1'b1; st.load_a = 1'b1; end
            StJzEv:   begin st.a_sel = 1'b1; st.pc_src = 1'b1; st.pc_write_con = 1'b1; end
            StBinEx:  begin st.a_sel = 1'b1; st.b_sel = 1'b1; st.alu_use_op = 1'b1; end
            StBinPu:  begin st.push = 1'b1; st.alu_use_op = 1'b1; end
            default:  st = '0;
        endcase
        return st;
    endfunction

    function automatic logic is_mem_state(state_e s);
        return (s == StFetch) || (s == StPushRd) || (s == StPopWr);
    endfunction

endpackage

// File: rtl/stack_ctrl_v2_if.sv
// Memory request/acknowledge bus between the controller and the memory.
interface stack_ctrl_v2_if;
    logic mem_read;
    logic mem_write;
    logic mem_sel;
    logic mem_ack;

    modport master (output mem_read, output mem_write, output mem_sel, input mem_ack);
    modport slave  (input mem_read, input mem_write, input mem_sel, output mem_ack);
endinterface

// File: rtl/stack_ctrl_v2_depth_tracker.sv
// Stack occupancy counter driven by the controller's own push/pop strobes.
module stack_ctrl_v2_depth_tracker #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DEPTH_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               has1,
    output logic               has2
);
    logic [DEPTH_W-1:0] cnt_q;

    assign full  = (cnt_q == DEPTH_W'(DEPTH));
    assign has1  = (cnt_q != '0);
    assign has2  = (cnt_q >= DEPTH_W'(2));
    assign depth = cnt_q;

    // Saturating up/down count; DECODE checks keep these guards from ever firing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push && !full) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (pop && has1) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/stack_ctrl_v2.sv
// Multicycle controller for the stack CPU with memory timeout and depth checking.
module stack_ctrl_v2
    import stack_ctrl_v2_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DEPTH_W     = 5,
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [2:0]         opcode,
    input  logic               alu_zero,
    stack_ctrl_v2_if.master    mem,
    output logic               pc_src,
    output logic               pc_write,
    output logic               pc_write_con,
    output logic               ir_write,
    output logic               stack_sel,
    output logic               load_a,
    output logic               a_sel,
    output logic               b_sel,
    output logic               push,
    output logic               pop,
    output logic               tos,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [DEPTH_W-1:0] depth,
    output logic               fault,
    output logic [1:0]         fault_code
);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    strobes_t          strobes_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W:0]   wait_inc;
    logic [1:0]        code_q, code_d;
    logic              fault_q;
    logic              full, has1, has2;
    logic              waiting, timeout_hit, fetch_ack;

    // The datapath gates pc_write_con with alu_zero itself.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    stack_ctrl_v2_depth_tracker #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk   (clk),
        .rst   (rst),
        .push  (strobes_q.push),
        .pop   (strobes_q.pop),
        .depth (depth),
        .full  (full),
        .has1  (has1),
        .has2  (has2)
    );

    assign waiting     = is_mem_state(state_q) && !mem.mem_ack;
    assign wait_inc    = {1'b0, wait_q} + 1'b1;
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc == (WAIT_W + 1)'(MEM_TIMEOUT));

    // Next state, fault code and wait counter.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        wait_d  = wait_q;
        case (state_q)
            StIdle:   if (run) state_d = StFetch;
            StFetch:  if (mem.mem_ack) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_PUSH: begin
                        if (full) begin state_d = StFault; code_d = FAULT_OVF; end
                        else      state_d = StPushRd;
                    end
                    OP_POP: begin
                        if (!has1) begin state_d = StFault; code_d = FAULT_UNF; end
                        else       state_d = StPopRd;
                    end
                    OP_NOT: begin
                        if (!has1) begin state_d = StFault; code_d = FAULT_UNF; end
                        else       state_d = StUnP;
                    end
                    OP_JZ: begin
                        if (!has1) begin state_d = StFault; code_d = FAULT_UNF; end
                        else       state_d = StJzTos;
                    end
                    OP_J: state_d = StJmp;
                    default: begin
                        if (!has2) begin state_d = StFault; code_d = FAULT_UNF; end
                        else       state_d = StBinP1;
                    end
                endcase
            end
            StPushRd: if (mem.mem_ack) state_d = StPushWr;
            StPushWr: state_d = StFetch;
            StPopRd:  state_d = StPopLd;
            StPopLd:  state_d = StPopWr;
            StPopWr:  if (mem.mem_ack) state_d = StFetch;
            StJmp:    state_d = StFetch;
            StJzTos:  state_d = StJzEv;
            StJzEv:   state_d = StFetch;
            StBinP1:  state_d = StBinLa;
            StBinLa:  state_d = StBinP2;
            StBinP2:  state_d = StBinEx;
            StBinEx:  state_d = StBinPu;
            StBinPu:  state_d = StFetch;
            StUnP:    state_d = StUnLa;
            StUnLa:   state_d = StBinEx;
            StFault:  state_d = StFault;
            default:  state_d = StIdle;
        endcase

        if (waiting && timeout_hit) begin
            state_d = StFault;
            code_d  = FAULT_TMO;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // State register with strobes registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            strobes_q <= '0;
            wait_q    <= '0;
            code_q    <= FAULT_NONE;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            strobes_q <= decode_strobes(state_d);
            wait_q    <= wait_d;
            code_q    <= code_d;
            fault_q   <= (state_d == StFault);
        end
    end

    // IR and PC load on the same cycle the fetch completes.
    assign fetch_ack = (state_q == StFetch) && mem.mem_ack;

    assign mem.mem_read  = strobes_q.mem_read;
    assign mem.mem_write = strobes_q.mem_write;
    assign mem.mem_sel   = strobes_q.mem_sel;
    assign pc_src        = strobes_q.pc_src;
    assign pc_write      = strobes_q.pc_write | fetch_ack;
    assign pc_write_con  = strobes_q.pc_write_con;
    assign ir_write      = fetch_ack;
    assign stack_sel     = strobes_q.stack_sel;
    assign load_a        = strobes_q.load_a;
    assign a_sel         = strobes_q.a_sel;
    assign b_sel         = strobes_q.b_sel;
    assign push          = strobes_q.push;
    assign pop           = strobes_q.pop;
    assign tos           = strobes_q.tos;
    assign alu_op        = strobes_q.alu_use_op ? ALUOP_W'(opcode) : ALUOP_W'(ALU_PASS);
    assign fault         = fault_q;
    assign fault_code    = code_q;
endmodule

// File: tb/tb_stack_ctrl_v2.sv
// Directed bench for stack_ctrl_v2: per-cycle strobe traces against hand-built tables.
module tb_stack_ctrl_v2;
    localparam logic [2:0] OP_ADD = 3'b000, OP_AND = 3'b010, OP_NOT = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100, OP_POP = 3'b101, OP_J = 3'b110, OP_JZ = 3'b111;

    localparam logic [13:0] PCSRC = 14'h2000, PCW = 14'h1000, PCWC = 14'h0800, MSEL = 14'h0400;
    localparam logic [13:0] MRD = 14'h0200, MWR = 14'h0100, IRW = 14'h0080, SSEL = 14'h0040;
    localparam logic [13:0] LDA = 14'h0020, ASEL = 14'h0010, BSEL = 14'h0008, PSH = 14'h0004;
    localparam logic [13:0] POP = 14'h0002, TOS = 14'h0001;
    localparam logic [13:0] FA = MRD | IRW | PCW;

    logic clk = 1'b0;
    logic rst, run, alu_zero;
    logic [2:0] opcode;
    logic pc_src, pc_write, pc_write_con, ir_write, stack_sel, load_a, a_sel, b_sel;
    logic push, pop, tos, fault;
    logic [2:0] alu_op;
    logic [4:0] depth;
    logic [1:0] fault_code;
    logic [13:0] sv;

    int total = 0;
    int bad = 0;

    logic [13:0] slog [0:31];
    logic [4:0]  dlog [0:31];
    logic [2:0]  alog [0:31];
    logic        flog [0:31];
    logic [1:0]  clog [0:31];

    stack_ctrl_v2_if mem_if ();

    stack_ctrl_v2 #(
        .DEPTH       (2),
        .DEPTH_W     (5),
        .ALUOP_W     (3),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .opcode       (opcode),
        .alu_zero     (alu_zero),
        .mem          (mem_if),
        .pc_src       (pc_src),
        .pc_write     (pc_write),
        .pc_write_con (pc_write_con),
        .ir_write     (ir_write),
        .stack_sel    (stack_sel),
        .load_a       (load_a),
        .a_sel        (a_sel),
        .b_sel        (b_sel),
        .push         (push),
        .pop          (pop),
        .tos          (tos),
        .alu_op       (alu_op),
        .depth        (depth),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    assign sv = {pc_src, pc_write, pc_write_con, mem_if.mem_sel, mem_if.mem_read, mem_if.mem_write,
                 ir_write, stack_sel, load_a, a_sel, b_sel, push, pop, tos};

    task automatic capture(input int c);
        slog[c] = sv;
        dlog[c] = depth;
        alog[c] = alu_op;
        flog[c] = fault;
        clog[c] = fault_code;
    endtask

    // Leaves the bench at a falling edge with run=1; the next rising edge enters FETCH.
    task automatic do_reset();
        rst = 1'b1; run = 1'b0; opcode = 3'b000; alu_zero = 1'b0; mem_if.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; run = 1'b1;
    endtask

    // Cycles 1..n with zero-wait memory, then one held FETCH (ack=0) as cycle n+1.
    task automatic exec(input logic [2:0] op, input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            opcode = op; mem_if.mem_ack = 1'b1;
            #1 capture(c);
        end
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        #1 capture(n + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; opcode = 3'b000; alu_zero = 1'b0; mem_if.mem_ack = 1'b1;
        @(negedge clk); #1;
        total++; if (sv !== 14'h0) begin bad++; $display("FAIL reset_strobes got=%h want=0", sv); end
        total++; if (depth !== 5'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", depth); end
        total++; if (fault !== 1'b0 || fault_code !== 2'b00) begin
            bad++; $display("FAIL reset_fault got=%b/%b want=0/00", fault, fault_code);
        end
        total++; if (alu_op !== 3'd0) begin bad++; $display("FAIL reset_aluop got=%0d want=0", alu_op); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (sv !== 14'h0) begin bad++; $display("FAIL idle_no_run got=%h want=0", sv); end
    endtask

    task automatic test_push();
        logic [13:0] exp [1:5];
        exp[1] = FA; exp[2] = 14'h0; exp[3] = MRD | MSEL; exp[4] = PSH | SSEL; exp[5] = MRD;
        do_reset();
        exec(OP_PUSH, 4);
        for (int c = 1; c <= 5; c++) begin
            total++; if (slog[c] !== exp[c]) begin
                bad++; $display("FAIL push_c%0d got=%h want=%h", c, slog[c], exp[c]);
            end
        end
        total++; if (dlog[4] !== 5'd0 || dlog[5] !== 5'd1) begin
            bad++; $display("FAIL push_depth got=%0d->%0d want=0->1", dlog[4], dlog[5]);
        end
    endtask

    task automatic test_binary();
        logic [13:0] exp [1:8];
        exp[1] = FA; exp[2] = 14'h0; exp[3] = POP; exp[4] = LDA;
        exp[5] = POP; exp[6] = ASEL | BSEL; exp[7] = PSH; exp[8] = MRD;
        do_reset();
        exec(OP_PUSH, 4);
        exec(OP_PUSH, 4);
        exec(OP_ADD, 7);
        for (int c = 1; c <= 8; c++) begin
            total++; if (slog[c] !== exp[c]) begin
                bad++; $display("FAIL add_c%0d got=%h want=%h", c, slog[c], exp[c]);
            end
        end
        total++; if (dlog[2] !== 5'd2 || dlog[4] !== 5'd1 || dlog[6] !== 5'd0 || dlog[8] !== 5'd1) begin
            bad++; $display("FAIL add_depth got=%0d,%0d,%0d,%0d want=2,1,0,1",
                            dlog[2], dlog[4], dlog[6], dlog[8]);
        end
        exec(OP_PUSH, 4);
        exec(OP_AND, 7);
        total++; if (alog[5] !== 3'd0 || alog[6] !== 3'd2 || alog[7] !== 3'd2) begin
            bad++; $display("FAIL and_aluop got=%0d,%0d,%0d want=0,2,2", alog[5], alog[6], alog[7]);
        end
        total++; if (slog[6] !== (ASEL | BSEL)) begin
            bad++; $display("FAIL and_ex got=%h want=%h", slog[6], ASEL | BSEL);
        end
    endtask

    task automatic test_not_jz_j_pop();
        do_reset();
        exec(OP_PUSH, 4);
        exec(OP_NOT, 6);
        total++; if (slog[3] !== POP || slog[4] !== LDA || slog[5] !== (ASEL | BSEL) || slog[6] !== PSH) begin
            bad++; $display("FAIL not_seq got=%h,%h,%h,%h want=%h,%h,%h,%h",
                            slog[3], slog[4], slog[5], slog[6], POP, LDA, ASEL | BSEL, PSH);
        end
        total++; if (alog[5] !== 3'd3 || alog[6] !== 3'd3 || dlog[7] !== 5'd1) begin
            bad++; $display("FAIL not_alu_depth got=%0d,%0d,d%0d want=3,3,d1", alog[5], alog[6], dlog[7]);
        end
        alu_zero = 1'b1;
        exec(OP_JZ, 4);
        total++; if (slog[3] !== (TOS | LDA)) begin
            bad++; $display("FAIL jz_tos got=%h want=%h", slog[3], TOS | LDA);
        end
        total++; if (slog[4] !== (ASEL | PCSRC | PCWC) || alog[4] !== 3'd0) begin
            bad++; $display("FAIL jz_ev got=%h/%0d want=%h/0", slog[4], alog[4], ASEL | PCSRC | PCWC);
        end
        total++; if (dlog[5] !== 5'd1 || slog[5] !== MRD) begin
            bad++; $display("FAIL jz_after got=%0d/%h want=1/%h", dlog[5], slog[5], MRD);
        end
        alu_zero = 1'b0;
        exec(OP_J, 3);
        total++; if (slog[3] !== (PCW | PCSRC) || slog[4] !== MRD) begin
            bad++; $display("FAIL j_seq got=%h,%h want=%h,%h", slog[3], slog[4], PCW | PCSRC, MRD);
        end
        exec(OP_POP, 5);
        total++; if (slog[3] !== POP || slog[4] !== LDA || slog[5] !== (MWR | MSEL)) begin
            bad++; $display("FAIL pop_seq got=%h,%h,%h want=%h,%h,%h",
                            slog[3], slog[4], slog[5], POP, LDA, MWR | MSEL);
        end
        total++; if (dlog[6] !== 5'd0 || slog[6] !== MRD) begin
            bad++; $display("FAIL pop_after got=%0d/%h want=0/%h", dlog[6], slog[6], MRD);
        end
    endtask

    task automatic test_faults();
        int errs;
        do_reset();
        exec(OP_PUSH, 4);
        exec(OP_PUSH, 4);
        exec(OP_PUSH, 2);
        total++; if (flog[2] !== 1'b0 || flog[3] !== 1'b1 || clog[3] !== 2'b01) begin
            bad++; $display("FAIL overflow got=%b,%b/%b want=0,1/01", flog[2], flog[3], clog[3]);
        end
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_if.mem_ack = c[0];
            #1;
            if (sv !== 14'h0 || fault !== 1'b1 || fault_code !== 2'b01 || depth !== 5'd2) errs++;
        end
        total++; if (errs !== 0) begin
            bad++; $display("FAIL fault_sticky got=%0d bad cycles want=0", errs);
        end
        do_reset();
        exec(OP_POP, 2);
        total++; if (flog[3] !== 1'b1 || clog[3] !== 2'b10 || slog[3] !== 14'h0) begin
            bad++; $display("FAIL underflow_pop got=%b/%b/%h want=1/10/0", flog[3], clog[3], slog[3]);
        end
        do_reset();
        exec(OP_PUSH, 4);
        exec(OP_ADD, 2);
        total++; if (flog[3] !== 1'b1 || clog[3] !== 2'b10) begin
            bad++; $display("FAIL underflow_add got=%b/%b want=1/10", flog[3], clog[3]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            mem_if.mem_ack = 1'b0;
            #1 capture(c);
        end
        total++; if (flog[15] !== 1'b0 || slog[15] !== MRD) begin
            bad++; $display("FAIL tmo_c15 got=%b/%h want=0/%h", flog[15], slog[15], MRD);
        end
        total++; if (flog[16] !== 1'b1 || clog[16] !== 2'b11 || slog[16] !== 14'h0) begin
            bad++; $display("FAIL tmo_c16 got=%b/%b/%h want=1/11/0", flog[16], clog[16], slog[16]);
        end
        do_reset();
        opcode = OP_J;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            mem_if.mem_ack = (c == 15);
            #1 capture(c);
        end
        total++; if (slog[15] !== FA || flog[16] !== 1'b0 || slog[16] !== 14'h0) begin
            bad++; $display("FAIL late_ack got=%h/%b/%h want=%h/0/0", slog[15], flog[16], slog[16], FA);
        end
        total++; if (slog[17] !== (PCW | PCSRC)) begin
            bad++; $display("FAIL late_ack_j got=%h want=%h", slog[17], PCW | PCSRC);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        exec(OP_PUSH, 4);
        exec(OP_PUSH, 4);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            opcode = OP_ADD; mem_if.mem_ack = 1'b1;
            #1 capture(c);
        end
        total++; if (slog[5] !== POP || dlog[5] !== 5'd1) begin
            bad++; $display("FAIL mid_binp2 got=%h/%0d want=%h/1", slog[5], dlog[5], POP);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        total++; if (sv !== 14'h0 || depth !== 5'd0 || fault !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%h/%0d/%b want=0/0/0", sv, depth, fault);
        end
        rst = 1'b0; run = 1'b1;
        exec(OP_PUSH, 4);
        total++; if (slog[1] !== FA || slog[4] !== (PSH | SSEL) || dlog[5] !== 5'd1) begin
            bad++; $display("FAIL mid_refetch got=%h,%h,d%0d want=%h,%h,d1",
                            slog[1], slog[4], dlog[5], FA, PSH | SSEL);
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_binary();
        test_not_jz_j_pop();
        test_faults();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
